// File: rtl/pc_branch_unit_if.sv
// pc_branch_unit_if
//   Groups the strobes, the target and the observable state of the PC/branch
//   unit into one bundle.
//   master : the sequencer side. It drives enable, the instruction class
//            strobes, jump and target, and observes the PC and stack status.
//   slave  : the PC/branch unit itself.
//   Signals:
//     enable     advance strobe
//     jump       comparator result (condition holds)
//     is_branch  conditional jump
//     is_jmp     unconditional jump
//     is_call    call (push return address, then jump)
//     is_ret     return (pop, jump to popped address)
//     target     absolute jump/call target
//     pc         current program counter (registered)
//     flush      one-cycle pulse after a taken control transfer
//     depth      valid return-stack entries
//     stack_ovf  sticky: push while full
//     stack_unf  sticky: pop while empty
interface pc_branch_unit_if;
  logic        enable;
  logic        jump;
  logic        is_branch;
  logic        is_jmp;
  logic        is_call;
  logic        is_ret;
  logic [15:0] target;
  logic [15:0] pc;
  logic        flush;
  logic [3:0]  depth;
  logic        stack_ovf;
  logic        stack_unf;

  modport master (
    output enable, jump, is_branch, is_jmp, is_call, is_ret, target,
    input  pc, flush, depth, stack_ovf, stack_unf
  );

  modport slave (
    input  enable, jump, is_branch, is_jmp, is_call, is_ret, target,
    output pc, flush, depth, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_branch_unit.sv
// pc_branch_unit
//   Program counter with branch/jump/call/return handling and a small
//   circular return-address stack.
//   Ports:
//     clk    sole clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    pc_branch_unit_if.slave (strobes/target in, pc/flush/stack status out)
//   Parameters:
//     RESET_PC   PC value loaded on reset
//     RAS_DEPTH  return-address stack depth, 2..8
//   Every output comes straight from a register.
module pc_branch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_branch_unit_if.slave  bus
);

  if (RAS_DEPTH < 2 || RAS_DEPTH > 8) begin : g_bad_depth
    $error("pc_branch_unit: RAS_DEPTH must be in 2..8");
  end

  localparam int              PTR_W     = (RAS_DEPTH > 4) ? 3 : (RAS_DEPTH > 2) ? 2 : 1;
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [3:0]       DEPTH_MAX = 4'(RAS_DEPTH);

  logic [15:0]      stack_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [PTR_W-1:0] top_up, top_dn;
  logic [15:0]      pc_q, pc_d, pc_inc;
  logic             flush_q, flush_d;
  logic [3:0]       depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;

  assign pc_inc = pc_q + 16'd1;

  // Pointer arithmetic wraps at RAS_DEPTH, which need not be a power of two.
  assign top_up = (top_q == PTR_MAX) ? '0 : top_q + 1'b1;
  assign top_dn = (top_q == '0) ? PTR_MAX : top_q - 1'b1;

  always_comb begin
    pc_d    = pc_q;
    flush_d = 1'b0;
    depth_d = depth_q;
    top_d   = top_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (bus.enable) begin
      if (bus.is_ret) begin
        if (depth_q != 4'd0) begin
          pc_d    = stack_mem[top_q];
          top_d   = top_dn;
          depth_d = depth_q - 4'd1;
          flush_d = 1'b1;
        end else begin
          // Empty-stack return degrades to a sequential step.
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (bus.is_call) begin
        // When full, advancing the top pointer lands on the oldest entry,
        // so the write below overwrites it and depth stays saturated.
        push    = 1'b1;
        top_d   = top_up;
        pc_d    = bus.target;
        flush_d = 1'b1;
        if (depth_q == DEPTH_MAX) begin
          ovf_d = 1'b1;
        end else begin
          depth_d = depth_q + 4'd1;
        end
      end else if (bus.is_jmp || (bus.is_branch && bus.jump)) begin
        pc_d    = bus.target;
        flush_d = 1'b1;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      depth_q <= 4'd0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
      depth_q <= depth_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      stack_mem[top_up] <= pc_inc;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.flush     = flush_q;
  assign bus.depth     = depth_q;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the PC value loaded on reset.
REQ-002 Parameter RAS_DEPTH, default 4, is the return-address stack depth; the legal range is 2-8.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 enable  input  1  advance strobe; the PC and stack update only in cycles where enable=1.
REQ-006 jump  input  1  condition result from the comparator stage; 1 means the condition holds.
REQ-007 is_branch  input  1  the current instruction is a conditional jump.
REQ-008 is_jmp  input  1  the current instruction is an unconditional jump.
REQ-009 is_call  input  1  the current instruction is a call: push the return address, then jump.
REQ-010 is_ret  input  1  the current instruction is a return: pop the stack and jump to the popped address.
REQ-011 target  input  16  absolute jump/call target (immediate N field).
REQ-012 pc  output  16  current program counter (registered).
REQ-013 flush  output  1  one-cycle registered pulse signalling that a control transfer was taken.
REQ-014 depth  output  4  number of valid stack entries, from 0 to RAS_DEPTH.
REQ-015 stack_ovf  output  1  sticky flag: a push occurred while the stack was full.
REQ-016 stack_unf  output  1  sticky flag: a pop occurred while the stack was empty.

Function
REQ-017 In an enabled cycle, the unit SHALL select the next PC by the fixed priority: is_ret, then is_call, then is_jmp, then (is_branch AND jump), then sequential.
REQ-018 A sequential step SHALL set pc to pc+1 modulo 2^16; 16'hFFFF wraps to 16'h0000 with no flag.
REQ-019 A taken branch, jmp or call SHALL load pc=target at the same clock edge, giving one-cycle latency from strobe to new pc.
REQ-020 A not-taken branch (is_branch=1, jump=0, no higher-priority strobe) SHALL step sequentially, and flush SHALL remain 0.
REQ-021 A call SHALL push pc+1 (with wrap) onto the stack and increment depth.
REQ-022 A call with depth=RAS_DEPTH SHALL discard the oldest entry, push the new one, leave depth unchanged, set stack_ovf, and still jump to target.
REQ-023 A return with depth>0 SHALL load pc with the top entry and decrement depth.
REQ-024 A return with depth=0 SHALL step pc sequentially, set stack_unf, leave depth at 0, and assert no flush.
REQ-025 flush SHALL be 1 in the cycle after every edge that performed a taken branch, jmp, call, or successful return, and 0 otherwise.
REQ-026 Back-to-back taken transfers SHALL keep flush high in consecutive cycles, one pulse per transfer.
REQ-027 With enable=0, the unit SHALL hold pc, the stack, depth and the flags, and clear flush to 0 at the next edge.
REQ-028 The stack SHALL be a circular buffer of RAS_DEPTH 16-bit entries with a top pointer; only depth and the top entry are architecturally visible.
REQ-029 The sticky flags SHALL clear only on reset.
REQ-030 The unit SHALL contain no combinational path from any input to any output.

Reset
REQ-031 rst_n=0 SHALL immediately and asynchronously force pc=RESET_PC, depth=0, flush=0, stack_ovf=0 and stack_unf=0; stack contents become don't-care.
REQ-032 Reset asserted mid-operation, including in the same cycle as a strobe, SHALL override the strobe; the first update after deassertion SHALL be at the first rising edge with rst_n=1.

Verification
REQ-033 Reset, then 3 enabled cycles with no strobes -> pc=0,1,2,3 and flush stays 0.
REQ-034 pc=16'hFFFF, enabled with no strobe -> pc=16'h0000; pc=16'h0010, is_branch=1, jump=1, target=16'h0040 -> pc=16'h0040 with flush=1 the next cycle; same stimulus with jump=0 -> pc=16'h0011 and flush=0.
REQ-035 Nested calls from pc=16'h0005, then 16'h0100, to targets 16'h0100 and 16'h0200, followed by two returns -> pc sequence 0100, 0200, 0101, 0006 and depth sequence 1, 2, 1, 0.
REQ-036 RAS_DEPTH+1 calls, then RAS_DEPTH+1 returns -> stack_ovf=1 after the last call; the last return steps sequentially and sets stack_unf=1.
REQ-037 is_ret, is_call and is_jmp asserted together with depth=1 -> the return wins, depth becomes 0, and target is ignored.
REQ-038 A call strobe with enable=0 -> no state change; rst_n pulsed low between clock edges -> pc=RESET_PC immediately, without waiting for a clock edge.
